// File: rtl/axis_pkt_traffic_gen_chk.sv
// AXI-Stream packet traffic generator and return-stream checker.
// Sends num_pkts packets of pattern (pkt + byte) mod 256, checks the returned stream and counts errors.
module axis_pkt_traffic_gen_chk #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  num_pkts,
    input  logic [LEN_WIDTH-1:0]  pkt_bytes,
    input  logic [7:0]            gap_cycles,
    input  logic                  bp_en,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [CNT_WIDTH-1:0]  tx_pkts,
    output logic [CNT_WIDTH-1:0]  rx_pkts,
    output logic [CNT_WIDTH-1:0]  err_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic [1:0]            state_q, state_d;
    logic [LEN_WIDTH-1:0]  tx_beat_q, tx_beat_d, rx_beat_q, rx_beat_d;
    logic [LEN_WIDTH-1:0]  last_idx_q, last_idx_d;
    logic [KEEP_WIDTH-1:0] last_keep_q, last_keep_d;
    logic [CNT_WIDTH-1:0]  npkts_q, npkts_d, tx_pkts_q, tx_pkts_d;
    logic [CNT_WIDTH-1:0]  rx_pkts_q, rx_pkts_d, err_q, err_d;
    logic [7:0]            gap_q, gap_d, gap_cnt_q, gap_cnt_d;
    logic [IDLE_W-1:0]     idle_q, idle_d;
    logic                  done_q, done_d, timeout_q, timeout_d, tready_q, tready_d;
    logic [15:0]           lfsr_q, lfsr_d;

    logic [LEN_WIDTH-1:0]  len_s, last_idx_s, rem_s;
    logic [KEEP_WIDTH-1:0] last_keep_s, rx_exp_keep;
    logic [7:0]            tx_base, rx_base;
    logic                  rx_exp_last, rx_bad, tx_fire, tx_end, rx_fire;

    // Packet geometry is computed once from the start-time length and held for the run.
    always_comb begin
        len_s      = (pkt_bytes == '0) ? LEN_WIDTH'(1) : pkt_bytes;
        last_idx_s = (len_s - LEN_WIDTH'(1)) / LEN_WIDTH'(KEEP_WIDTH);
        rem_s      = len_s % LEN_WIDTH'(KEEP_WIDTH);
        for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
            last_keep_s[i] = (rem_s == '0) || (LEN_WIDTH'(i) < rem_s);
        end
    end

    always_comb begin
        tx_base       = tx_pkts_q[7:0] + 8'(tx_beat_q * KEEP_WIDTH);
        m_axis_tlast  = (tx_beat_q == last_idx_q);
        m_axis_tkeep  = m_axis_tlast ? last_keep_q : '1;
        m_axis_tvalid = (state_q == ST_SEND);
        m_axis_tdata  = '0;
        for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
            m_axis_tdata[8*i +: 8] = tx_base + 8'(i);
        end
    end

    // Beats past the expected end (late tlast) are compared as if still on the last beat.
    always_comb begin
        rx_base     = rx_pkts_q[7:0] + 8'(rx_beat_q * KEEP_WIDTH);
        rx_exp_last = (rx_beat_q >= last_idx_q);
        rx_exp_keep = rx_exp_last ? last_keep_q : '1;
        rx_bad      = (s_axis_tkeep != rx_exp_keep) || (s_axis_tlast != rx_exp_last);
        for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
            if (rx_exp_keep[i] && (s_axis_tdata[8*i +: 8] != rx_base + 8'(i))) begin
                rx_bad = 1'b1;
            end
        end
    end

    assign tx_fire = m_axis_tvalid && m_axis_tready;
    assign tx_end  = m_axis_tlast;
    assign rx_fire = s_axis_tvalid && s_axis_tready;

    always_comb begin
        state_d     = state_q;
        tx_beat_d   = tx_beat_q;
        rx_beat_d   = rx_beat_q;
        last_idx_d  = last_idx_q;
        last_keep_d = last_keep_q;
        npkts_d     = npkts_q;
        tx_pkts_d   = tx_pkts_q;
        rx_pkts_d   = rx_pkts_q;
        err_d       = err_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        idle_d      = '0;
        done_d      = 1'b0;
        timeout_d   = timeout_q;
        lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        case (state_q)
            ST_IDLE: begin
                if (start && !done_q) begin
                    tx_beat_d   = '0;
                    rx_beat_d   = '0;
                    tx_pkts_d   = '0;
                    rx_pkts_d   = '0;
                    err_d       = '0;
                    timeout_d   = 1'b0;
                    npkts_d     = num_pkts;
                    gap_d       = gap_cycles;
                    last_idx_d  = last_idx_s;
                    last_keep_d = last_keep_s;
                    if (num_pkts == '0) done_d = 1'b1;
                    else                state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_fire) begin
                    if (tx_end) begin
                        tx_beat_d = '0;
                        tx_pkts_d = sat_inc(tx_pkts_q);
                        if (tx_pkts_q == npkts_q - CNT_WIDTH'(1)) begin
                            state_d = ST_WAIT;
                        end else if (gap_q != '0) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = gap_q;
                        end
                    end else begin
                        tx_beat_d = tx_beat_q + LEN_WIDTH'(1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 8'd1) state_d = ST_SEND;
                else                   gap_cnt_d = gap_cnt_q - 8'd1;
            end
            ST_WAIT: begin
                if (rx_pkts_q >= npkts_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (rx_fire) begin
                    idle_d = '0;
                end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (busy && rx_fire) begin
            if (rx_bad) err_d = sat_inc(err_q);
            if (s_axis_tlast) begin
                rx_pkts_d = sat_inc(rx_pkts_q);
                rx_beat_d = '0;
            end else if (!(&rx_beat_q)) begin
                rx_beat_d = rx_beat_q + LEN_WIDTH'(1);
            end
        end
        tready_d = ((state_d != ST_IDLE) && bp_en) ? lfsr_d[0] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            tx_beat_q   <= '0;
            rx_beat_q   <= '0;
            last_idx_q  <= '0;
            last_keep_q <= '0;
            npkts_q     <= '0;
            tx_pkts_q   <= '0;
            rx_pkts_q   <= '0;
            err_q       <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            idle_q      <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            tready_q    <= 1'b0;
            lfsr_q      <= 16'h0001;
        end else begin
            state_q     <= state_d;
            tx_beat_q   <= tx_beat_d;
            rx_beat_q   <= rx_beat_d;
            last_idx_q  <= last_idx_d;
            last_keep_q <= last_keep_d;
            npkts_q     <= npkts_d;
            tx_pkts_q   <= tx_pkts_d;
            rx_pkts_q   <= rx_pkts_d;
            err_q       <= err_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            idle_q      <= idle_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            tready_q    <= tready_d;
            lfsr_q      <= lfsr_d;
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign timeout       = timeout_q;
    assign s_axis_tready = tready_q;
    assign tx_pkts       = tx_pkts_q;
    assign rx_pkts       = rx_pkts_q;
    assign err_count     = err_q;

endmodule

// File: tb/tb_axis_pkt_traffic_gen_chk.sv
// Bench: bench-side loopback "DUT" with optional corruption/drop, plus a byte-level model of the TX pattern.
module tb_axis_pkt_traffic_gen_chk;

    localparam int DW = 64;
    localparam int KW = DW / 8;
    localparam int CW = 16;
    localparam int LW = 16;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          reset, start, bp_en;
    logic [CW-1:0] num_pkts;
    logic [LW-1:0] pkt_bytes;
    logic [7:0]    gap_cycles;
    logic [DW-1:0] m_axis_tdata, s_axis_tdata;
    logic [KW-1:0] m_axis_tkeep, s_axis_tkeep;
    logic          m_axis_tlast, m_axis_tvalid, m_axis_tready;
    logic          s_axis_tlast, s_axis_tvalid, s_axis_tready;
    logic          busy, done, timeout;
    logic [CW-1:0] tx_pkts, rx_pkts, err_count;

    always #5 clk = ~clk;

    axis_pkt_traffic_gen_chk #(
        .DATA_WIDTH(DW),
        .LEN_WIDTH (LW),
        .CNT_WIDTH (CW),
        .TIMEOUT   (TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_pkts(num_pkts),
        .pkt_bytes(pkt_bytes), .gap_cycles(gap_cycles), .bp_en(bp_en),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .busy(busy), .done(done), .timeout(timeout),
        .tx_pkts(tx_pkts), .rx_pkts(rx_pkts), .err_count(err_count)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;
    beat_t lbq[$];

    int total = 0;
    int bad   = 0;
    int m_n, m_len, m_gap, tp, tb, tx_beats, done_cnt, cyc;
    int last_tx_cyc, done_cyc, gap_cnt, rmode, fault, lb_pkt, lb_beat;
    bit gap_mode, stalled, tgl;
    logic [DW-1:0] h_d;
    logic [KW-1:0] h_k;
    logic          h_l;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference beat b of packet p for an L-byte packet, straight from the byte rule.
    task automatic exp_beat(input int p, input int b, input int L,
                            output logic [DW-1:0] d, output logic [KW-1:0] k, output logic l);
        d = '0;
        k = '0;
        for (int i = 0; i < KW; i++) begin
            int idx;
            idx = b * KW + i;
            if (idx < L) begin
                k[i]       = 1'b1;
                d[8*i +: 8] = 8'((p + idx) % 256);
            end
        end
        l = ((b + 1) * KW >= L);
    endtask

    initial begin
        logic [DW-1:0] sd, ed, mask;
        logic [KW-1:0] sk, ek;
        logic          sl, el;
        bit            hs_m, hs_s;
        beat_t         b;
        cyc = 0; done_cnt = 0; stalled = 0; gap_mode = 0; tgl = 0;
        forever begin
            @(negedge clk);
            cyc++;
            hs_m = m_axis_tvalid && m_axis_tready && !reset;
            hs_s = s_axis_tvalid && s_axis_tready && !reset;
            sd = m_axis_tdata; sk = m_axis_tkeep; sl = m_axis_tlast;
            if (reset) begin
                stalled  = 0;
                gap_mode = 0;
            end else begin
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (stalled && m_axis_tvalid) begin
                    check("hold_data", m_axis_tdata, h_d);
                    check("hold_keep", 64'(m_axis_tkeep), 64'(h_k));
                    check("hold_last", 64'(m_axis_tlast), 64'(h_l));
                end
                stalled = m_axis_tvalid && !m_axis_tready;
                h_d = sd; h_k = sk; h_l = sl;
                if (gap_mode) begin
                    if (m_axis_tvalid) begin
                        check("gap_len", 64'(gap_cnt), 64'(m_gap));
                        gap_mode = 0;
                    end else begin
                        gap_cnt++;
                    end
                end
                if (hs_m) begin
                    exp_beat(tp, tb, m_len, ed, ek, el);
                    mask = '0;
                    for (int i = 0; i < KW; i++) if (ek[i]) mask[8*i +: 8] = 8'hFF;
                    check("tx_data", sd & mask, ed);
                    check("tx_keep", 64'(sk), 64'(ek));
                    check("tx_last", 64'(sl), 64'(el));
                    tx_beats++;
                    if (el) begin
                        tp++;
                        tb = 0;
                        if (tp < m_n) begin
                            gap_mode = 1;
                            gap_cnt  = 0;
                        end else begin
                            last_tx_cyc = cyc;
                        end
                    end else begin
                        tb++;
                    end
                end
            end
            @(posedge clk);
            #1;
            if (reset) begin
                lbq.delete();
            end else begin
                if (hs_s && lbq.size() > 0) void'(lbq.pop_front());
                if (hs_m) begin
                    b.d = sd; b.k = sk; b.l = sl;
                    if (fault == 1 && lb_pkt == 1 && lb_beat == 0) b.d[24] = ~b.d[24];
                    if (!(fault == 2 && lb_pkt == m_n - 1)) lbq.push_back(b);
                    if (sl) begin
                        lb_pkt++;
                        lb_beat = 0;
                    end else begin
                        lb_beat++;
                    end
                end
            end
            if (lbq.size() > 0) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = lbq[0].d;
                s_axis_tkeep  = lbq[0].k;
                s_axis_tlast  = lbq[0].l;
            end else begin
                s_axis_tvalid = 1'b0;
                s_axis_tdata  = '0;
                s_axis_tkeep  = '0;
                s_axis_tlast  = 1'b0;
            end
            case (rmode)
                1:       begin tgl = ~tgl; m_axis_tready = tgl; end
                2:       m_axis_tready = ($urandom_range(0, 3) != 0);
                default: m_axis_tready = 1'b1;
            endcase
        end
    end

    task automatic prep(input int n, input int bytes, input int gap, input bit bp,
                        input int rm, input int flt);
        m_n = n; m_len = (bytes == 0) ? 1 : bytes; m_gap = gap;
        tp = 0; tb = 0; tx_beats = 0; rmode = rm; fault = flt;
        lb_pkt = 0; lb_beat = 0; last_tx_cyc = 0; done_cyc = 0;
        num_pkts = CW'(n); pkt_bytes = LW'(bytes); gap_cycles = 8'(gap); bp_en = bp;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run(input string nm, input int n, input int bytes, input int gap, input bit bp,
                       input int rm, input int flt, input int exp_err, input int exp_rx,
                       input bit exp_to, input bit poke, input bit sod, input int budget);
        int d0;
        bit seen;
        d0 = done_cnt;
        prep(n, bytes, gap, bp, rm, flt);
        if (poke) begin
            num_pkts = CW'(n + 4);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        check({nm, "_done_seen"}, 64'(seen), 64'(1));
        if (sod) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        repeat (3) @(negedge clk);
        check({nm, "_busy_after"}, 64'(busy), 64'(0));
        check({nm, "_done_pulses"}, 64'(done_cnt - d0), 64'(1));
        check({nm, "_tx_pkts"}, 64'(tx_pkts), 64'(n));
        check({nm, "_rx_pkts"}, 64'(rx_pkts), 64'(exp_rx));
        check({nm, "_err"}, 64'(err_count), 64'(exp_err));
        check({nm, "_timeout"}, 64'(timeout), 64'(exp_to));
        check({nm, "_tx_beats"}, 64'(tx_beats), 64'(n * ((m_len + KW - 1) / KW)));
        if (exp_to) begin
            check({nm, "_to_latency_ok"},
                  64'((done_cyc - last_tx_cyc >= TO) && (done_cyc - last_tx_cyc <= TO + 2)), 64'(1));
        end
    endtask

    initial begin
        int d0;
        bit hit;
        beat_t junk;
        reset = 1'b1; start = 1'b0; bp_en = 1'b0; num_pkts = '0; pkt_bytes = '0; gap_cycles = '0;
        m_axis_tready = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
        s_axis_tlast = 1'b0; rmode = 0; fault = 0; m_n = 0; m_len = 1; m_gap = 0;
        tp = 0; tb = 0; tx_beats = 0; lb_pkt = 0; lb_beat = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        check("rst_tready", 64'(s_axis_tready), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_timeout", 64'(timeout), 64'(0));
        check("rst_counters", 64'({tx_pkts, rx_pkts, err_count}), 64'(0));
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_tready", 64'(s_axis_tready), 64'(1));

        // Zero-packet start: immediate done, never busy.
        num_pkts = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("zero_done", 64'(done), 64'(1));
        check("zero_busy", 64'(busy), 64'(0));
        @(posedge clk); #1;
        check("zero_done_clr", 64'(done), 64'(0));

        run("t1", 3, 20, 0, 1'b0, 0, 0, 0, 3, 1'b0, 1'b1, 1'b0, 2000);

        // A beat arriving while idle is taken and ignored.
        @(negedge clk); #2;
        junk.d = '1; junk.k = '1; junk.l = 1'b1;
        lbq.push_back(junk);
        repeat (5) @(posedge clk);
        #1;
        check("idle_drain", 64'(lbq.size()), 64'(0));
        check("idle_rx_pkts", 64'(rx_pkts), 64'(3));
        check("idle_err", 64'(err_count), 64'(0));

        run("t2", 4, 8, 0, 1'b0, 1, 0, 0, 4, 1'b0, 1'b0, 1'b1, 2000);
        run("t3", 100, 1500, 5, 1'b1, 0, 0, 0, 100, 1'b0, 1'b0, 1'b0, 80000);
        run("t4", 4, 64, 2, 1'b1, 2, 1, 1, 4, 1'b0, 1'b0, 1'b0, 4000);
        run("t5", 3, 40, 1, 1'b0, 0, 2, 0, 2, 1'b1, 1'b0, 1'b0, 2000);

        // Abort mid-packet with reset, then restart with 1-byte packets.
        d0 = done_cnt;
        prep(4, 200, 0, 1'b0, 0, 0);
        hit = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (tx_beats >= 3) begin
                hit = 1;
                break;
            end
        end
        check("t6_reached_mid", 64'(hit), 64'(1));
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("t6_tvalid_drop", 64'(m_axis_tvalid), 64'(0));
        check("t6_busy_drop", 64'(busy), 64'(0));
        check("t6_cnt_clear", 64'({tx_pkts, rx_pkts, err_count}), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_no_done", 64'(done_cnt - d0), 64'(0));
        run("t6", 5, 0, 1, 1'b1, 2, 0, 0, 5, 1'b0, 1'b0, 1'b0, 2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
